barrel_shifter: RTL and testbench
=================================

# barrel_shifter

Registered 8-bit logarithmic barrel shifter. Shifts an input byte right by 0–7 positions in a single clock cycle. Used as a datapath utility wherever a variable right shift or rotate is needed, for example in normalisation, field extraction or serialisation front-ends. Built as three mux stages (shift by 4, 2, 1) followed by an output register with a valid flag.

## Interface
Parameters:
- WIDTH, default 8: data width in bits. Must be a power of two, at least 2.
- SHW, default $clog2(WIDTH) (= 3): width of the shift-amount port.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; one clock, synchronous, active-high.
- in_valid  input  1  qualifies in/ctrl for capture this cycle.
- in  input  WIDTH  data to shift.
- ctrl  input  SHW  shift amount, unsigned, 0..WIDTH-1.
- out  output  WIDTH  registered shifted result.
- out_valid  output  1  high for exactly the cycle after an accepted input.

## Operation
- Shift direction is always right: towards the LSB.
- The shift is computed combinationally from in and ctrl in log2(WIDTH) stages. Stage k is controlled by ctrl[k] and shifts by 2^k. Stages are applied MSB-first: 4, then 2, then 1.
- Default mode is a logical shift right.
  - Vacated MSBs are filled with 0.
  - Result equals in >> ctrl.
- Rotate mode, when compiled in (see Configuration):
  - Bits shifted out of the LSB re-enter at the MSB.
  - Result equals (in >> ctrl) | (in << (WIDTH-ctrl)), truncated to WIDTH bits.
- ctrl = 0 passes in through unchanged in both modes.
- Every ctrl code is legal; there is no out-of-range value.
- Arithmetic (sign-fill) shift is not supported.
- When in_valid = 1, out captures the shifted result.
- When in_valid = 0, out holds its previous value. Its combinational inputs are don't-care.

## Timing
- Latency is 1 cycle: an input accepted at edge N appears on out after edge N. out_valid is high from edge N to edge N+1.
- Throughput is one result per cycle. There is no backpressure and no ready signal.
- out_valid is cleared on any edge where in_valid = 0.
- Reset values: out = 0, out_valid = 0.
- Reset priority: rst = 1 overrides in_valid on the same edge. Nothing is captured and the outputs go to 0.
- Reset asserted while a result is held clears it. The first valid input after rst deasserts is captured normally on that edge.
- Each input sample is independent; no state carries between samples other than the hold value.
- There is no combinational path from in, ctrl or in_valid to any output.

## Configuration
- Macro: BARREL_SHIFTER_ROTATE_EN.
- Defined: rotate-right mode. Vacated MSBs are filled from the bits shifted out of the LSB end.
- Undefined (default): logical right shift with zero fill. The rotate wrap-around logic is not compiled.
- The port list and timing are identical in both builds.

## Test plan
- Reset: hold rst = 1 for 2 cycles with in_valid = 1, in = 0xFF. Required: out = 0x00 and out_valid = 0 throughout. After release, in = 0x00, ctrl = 0 gives out = 0x00 and out_valid = 1 one cycle later.
- Power-of-two shifts: in = 0x80 with ctrl = 4, 2, 1, 3, 5 on consecutive cycles. Required: out = 0x08, 0x20, 0x40, 0x10, 0x04 respectively, each one cycle after issue, with out_valid = 1 each cycle (both builds).
- Full shift: in = 0xFF, ctrl = 7 gives out = 0x01 in the default build and 0xFF in the ROTATE build. in = 0xFF, ctrl = 4 gives 0x0F in the default build and 0xFF in the ROTATE build.
- Wrap-around: in = 0x81, ctrl = 1 gives 0x40 in the default build and 0xC0 in the ROTATE build. in = 0xA5, ctrl = 3 gives 0x14 in the default build and 0xB4 in the ROTATE build.
- Hold and valid: accept in = 0x80, ctrl = 2 (out = 0x20). Then drop in_valid for 3 cycles while changing in and ctrl. Required: out stays 0x20 and out_valid = 0 for those cycles.
- Reset collision: assert rst and in_valid on the same edge with in = 0x80, ctrl = 0. Required: out = 0x00 and out_valid = 0 after that edge.

Source files
------------

// File: rtl/barrel_shifter.sv
// Registered logarithmic right barrel shifter: log2(WIDTH) mux stages, then an output register.
// Define BARREL_SHIFTER_ROTATE_EN for rotate-right; the default build is a logical shift with zero fill.
module barrel_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   ctrl,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] out_reg;
    logic             out_valid_reg;

    // Stage gi shifts by 2**gi under ctrl[gi]; the highest stage sees the raw input,
    // so the data passes the largest shift first and the 1-bit stage last.
    genvar gi;
    generate
        for (gi = 0; gi < SHW; gi++) begin : gen_stage
            localparam int S = 1 << gi;
            logic [WIDTH-1:0] x;
            logic [WIDTH-1:0] y;

            if (gi == SHW - 1) begin : g_first
                assign x = in;
            end else begin : g_chain
                assign x = gen_stage[gi+1].y;
            end

`ifdef BARREL_SHIFTER_ROTATE_EN
            assign y = ctrl[gi] ? {x[S-1:0], x[WIDTH-1:S]} : x;
`else
            assign y = ctrl[gi] ? {{S{1'b0}}, x[WIDTH-1:S]} : x;
`endif
        end
    endgenerate

    assign shifted = gen_stage[0].y;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                out_reg <= shifted;
            end
        end
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_barrel_shifter.sv
// Scoreboard bench for barrel_shifter: the driver queues the expected output for each
// edge, a negedge monitor pops and compares. Expectations track BARREL_SHIFTER_ROTATE_EN.
module tb_barrel_shifter;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] din;
    logic [2:0] ctrl;
    logic [7:0] dout;
    logic       out_valid;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_txn  = 0;

    barrel_shifter #(.WIDTH(8), .SHW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (din),
        .ctrl      (ctrl),
        .out       (dout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One edge of stimulus; the expectation is queued at the capturing edge.
    task automatic drive(input logic r, input logic v, input logic [7:0] d,
                         input logic [2:0] c, input logic ev, input logic [7:0] ed);
        exp_t e;
        rst      = r;
        in_valid = v;
        din      = d;
        ctrl     = c;
        @(posedge clk);
        e.v = ev;
        e.d = ed;
        exp_q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_txn++;
            $display("txn %0d: out_valid=%0b out=%02h (want %0b/%02h)", n_txn, out_valid, dout, e.v, e.d);
            n_chk++;
            if (out_valid === e.v) n_pass++;
            else $display("FAIL txn%0d out_valid: got %0b want %0b", n_txn, out_valid, e.v);
            n_chk++;
            if (dout === e.d) n_pass++;
            else $display("FAIL txn%0d out: got %02h want %02h", n_txn, dout, e.d);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; din = 8'h00; ctrl = 3'd0;

        // Reset held two cycles with valid data present
        drive(1'b1, 1'b1, 8'hFF, 3'd0, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'hFF, 3'd0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'h00, 3'd0, 1'b1, 8'h00);

        // Single MSB bit: no wrap, same result in both builds
        drive(1'b0, 1'b1, 8'h80, 3'd4, 1'b1, 8'h08);
        drive(1'b0, 1'b1, 8'h80, 3'd2, 1'b1, 8'h20);
        drive(1'b0, 1'b1, 8'h80, 3'd1, 1'b1, 8'h40);
        drive(1'b0, 1'b1, 8'h80, 3'd3, 1'b1, 8'h10);
        drive(1'b0, 1'b1, 8'h80, 3'd5, 1'b1, 8'h04);
        drive(1'b0, 1'b1, 8'h01, 3'd0, 1'b1, 8'h01);

`ifdef BARREL_SHIFTER_ROTATE_EN
        drive(1'b0, 1'b1, 8'hFF, 3'd7, 1'b1, 8'hFF);
        drive(1'b0, 1'b1, 8'hFF, 3'd4, 1'b1, 8'hFF);
        drive(1'b0, 1'b1, 8'h81, 3'd1, 1'b1, 8'hC0);
        drive(1'b0, 1'b1, 8'hA5, 3'd3, 1'b1, 8'hB4);
        drive(1'b0, 1'b1, 8'hC3, 3'd6, 1'b1, 8'h0F);
        drive(1'b0, 1'b1, 8'h3C, 3'd2, 1'b1, 8'h0F);
`else
        drive(1'b0, 1'b1, 8'hFF, 3'd7, 1'b1, 8'h01);
        drive(1'b0, 1'b1, 8'hFF, 3'd4, 1'b1, 8'h0F);
        drive(1'b0, 1'b1, 8'h81, 3'd1, 1'b1, 8'h40);
        drive(1'b0, 1'b1, 8'hA5, 3'd3, 1'b1, 8'h14);
        drive(1'b0, 1'b1, 8'hC3, 3'd6, 1'b1, 8'h03);
        drive(1'b0, 1'b1, 8'h3C, 3'd2, 1'b1, 8'h0F);
`endif

        // Hold: out keeps 0x20 while in_valid is low and inputs wander
        drive(1'b0, 1'b1, 8'h80, 3'd2, 1'b1, 8'h20);
        drive(1'b0, 1'b0, 8'hFF, 3'd7, 1'b0, 8'h20);
        drive(1'b0, 1'b0, 8'h55, 3'd0, 1'b0, 8'h20);
        drive(1'b0, 1'b0, 8'hAA, 3'd3, 1'b0, 8'h20);

        // Reset collides with a valid input, then first valid after release
        drive(1'b0, 1'b1, 8'hF0, 3'd0, 1'b1, 8'hF0);
        drive(1'b1, 1'b1, 8'h80, 3'd0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'h5A, 3'd0, 1'b1, 8'h5A);
        drive(1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h5A);

        @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
